// File: rtl/mem_access_unit.sv
// mem_access_unit
// ----------------------------------------------------------------------------
// Load/store unit between the stage-2 register block and a single-port data
// memory with a request/ack handshake. An access is checked for alignment,
// registered, and presented to memory until an ack arrives or the wait
// counter reaches TIMEOUT-1. Loads are lane-shifted and sign/zero-extended
// into load_data_out. Stores replicate data across lanes and drive a
// byte-lane mask.
//
// Ports
//   clk_in            sole clock, rising edge
//   rst_in            asynchronous active-low reset
//   mem_rd_req_in     load request
//   mem_wr_req_in     store request (wins over a load when both are set)
//   iadder_in[31:0]   effective byte address
//   rs2_in[31:0]      store data
//   load_size_in[1:0] 00 byte, 01 half, 10/11 word
//   load_unsigned_in  1 = zero-extend, 0 = sign-extend
//   dmem_ack_in       memory completion strobe
//   dmem_rdata_in     memory read word, valid with dmem_ack_in
//   dmem_req_out      memory request, held until ack or timeout
//   dmem_we_out       1 = write transfer
//   dmem_addr_out     word-aligned address
//   dmem_wdata_out    lane-replicated store data
//   dmem_wr_mask_out  byte-lane enables (0000 for loads)
//   load_data_out     extended load result, held between loads
//   load_valid_out    one-cycle pulse, load_data_out updated
//   stall_out         hold upstream pipeline (combinational)
//   misaligned_out    one-cycle pulse, misaligned access rejected
//   access_fault_out  one-cycle pulse, bus timeout
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        dmem_ack_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wr_mask_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        access_fault_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last counter value still spent waiting; reaching it without ack faults.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  // Half needs addr[0]=0, word (and size 11) needs addr[1:0]=00.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

  // Byte-lane enables for a store.
  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lo;
      2'b01:   m = 4'b0011 << lo;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Move the addressed lane to bit 0, then extend.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic        uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {lo, 3'b000};
    case (size)
      2'b00: begin
        if (uns) begin
          r = {24'h000000, sh[7:0]};
        end else begin
          r = {{24{sh[7]}}, sh[7:0]};
        end
      end
      2'b01: begin
        if (uns) begin
          r = {16'h0000, sh[15:0]};
        end else begin
          r = {{16{sh[15]}}, sh[15:0]};
        end
      end
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  mask_r;
  logic [1:0]  size_r;
  logic [1:0]  lo_r;
  logic        uns_r;
  logic [31:0] load_data_r;
  logic        load_valid_r;
  logic        misaligned_r;
  logic        fault_r;

  logic        req_any_s;
  logic        aligned_s;
  logic        stall_s;

  assign req_any_s = mem_rd_req_in | mem_wr_req_in;
  assign aligned_s = is_aligned(load_size_in, iadder_in[1:0]);

  // Upstream hold: aligned request being accepted, or waiting on memory.
  // Gated by reset so nothing is reported while the unit is held in reset.
  always_comb begin
    stall_s = 1'b0;
    if (!rst_in) begin
      stall_s = 1'b0;
    end else if (state_r == IDLE) begin
      stall_s = req_any_s & aligned_s;
    end else begin
      stall_s = ~dmem_ack_in;
    end
  end

  // Access FSM, wait counter and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      mask_r       <= 4'b0000;
      size_r       <= 2'b00;
      lo_r         <= 2'b00;
      uns_r        <= 1'b0;
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      misaligned_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      load_valid_r <= 1'b0;
      misaligned_r <= 1'b0;
      fault_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_any_s && aligned_s) begin
            state_r <= BUSY;
            cnt_r   <= 8'd0;
            req_r   <= 1'b1;
            we_r    <= mem_wr_req_in;
            addr_r  <= {iadder_in[31:2], 2'b00};
            size_r  <= load_size_in;
            lo_r    <= iadder_in[1:0];
            uns_r   <= load_unsigned_in;
            if (mem_wr_req_in) begin
              wdata_r <= store_data(load_size_in, rs2_in);
              mask_r  <= store_mask(load_size_in, iadder_in[1:0]);
            end else begin
              wdata_r <= 32'h0000_0000;
              mask_r  <= 4'b0000;
            end
          end else if (req_any_s) begin
            misaligned_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // Ack is tested first so it beats a coincident timeout.
          if (dmem_ack_in) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
            mask_r  <= 4'b0000;
            if (!we_r) begin
              load_data_r  <= load_extract(dmem_rdata_in, size_r, lo_r, uns_r);
              load_valid_r <= 1'b1;
            end else begin
              load_valid_r <= 1'b0;
            end
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
            mask_r  <= 4'b0000;
            fault_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 8'd0;
          req_r   <= 1'b0;
          we_r    <= 1'b0;
          mask_r  <= 4'b0000;
        end
      endcase
    end
  end

  assign dmem_req_out     = req_r;
  assign dmem_we_out      = we_r;
  assign dmem_addr_out    = addr_r;
  assign dmem_wdata_out   = wdata_r;
  assign dmem_wr_mask_out = mask_r;
  assign load_data_out    = load_data_r;
  assign load_valid_out   = load_valid_r;
  assign stall_out        = stall_s;
  assign misaligned_out   = misaligned_r;
  assign access_fault_out = fault_r;

endmodule
